// File: rtl/device_special_access_pkg.sv
// -----------------------------------------------------------------------------
// device_special_access_pkg
// Shared definitions for the special-space access controller: FSM state
// encoding, request-queue entry layout, address-decode constants and the
// address legality check.
// -----------------------------------------------------------------------------
package device_special_access_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_RESP  = 2'd2
    } state_t;

    // Entry field widths
    localparam int RW_W    = 1;
    localparam int ERR_W   = 1;
    localparam int RO_W    = 1;
    localparam int INDEX_W = 8;
    localparam int DATA_W  = 32;
    localparam int ADDR_W  = 32;

    // Byte address layout: [1:0] must be zero, [9:2] word index, [31:10] zero
    localparam int INDEX_LSB = 2;
    localparam int INDEX_MSB = INDEX_LSB + INDEX_W - 1;

    typedef struct packed {
        logic [RW_W-1:0]    rw;     // 1 = write
        logic [ERR_W-1:0]   err;    // illegal address, never reaches memory
        logic [RO_W-1:0]    ro;     // write to read-only word, silently dropped
        logic [INDEX_W-1:0] index;
        logic [DATA_W-1:0]  data;   // write data, zero for reads
    } req_entry_t;

    localparam int ENTRY_W = $bits(req_entry_t);

    // Misaligned or outside the 1 KiB special window
    function automatic logic addr_is_err(input logic [ADDR_W-1:0] addr);
        return (addr[INDEX_LSB-1:0] != '0) || (addr[ADDR_W-1:INDEX_MSB+1] != '0);
    endfunction

endpackage

// File: rtl/device_special_access_if.sv
// -----------------------------------------------------------------------------
// device_special_access_if
// Bundles the requester bus and the special-memory port of the controller.
//   iBUS_REQ/RW/ADDR/DATA  request from requester
//   oBUS_BUSY              request queue full
//   oBUS_VALID/ERR/DATA    response to requester
//   iBUS_BUSY              requester back-pressure on responses
//   oSPECIAL_REQ/RW/ADDR/DATA  special-memory access
//   iSPECIAL_DATA          special-memory combinational read data
// slave  : the controller side
// master : the requester / memory side
// -----------------------------------------------------------------------------
interface device_special_access_if;
    import device_special_access_pkg::*;

    logic                iBUS_REQ;
    logic                oBUS_BUSY;
    logic                iBUS_RW;
    logic [ADDR_W-1:0]   iBUS_ADDR;
    logic [DATA_W-1:0]   iBUS_DATA;
    logic                oBUS_VALID;
    logic                oBUS_ERR;
    logic [DATA_W-1:0]   oBUS_DATA;
    logic                iBUS_BUSY;
    logic                oSPECIAL_REQ;
    logic                oSPECIAL_RW;
    logic [INDEX_W-1:0]  oSPECIAL_ADDR;
    logic [DATA_W-1:0]   oSPECIAL_DATA;
    logic [DATA_W-1:0]   iSPECIAL_DATA;

    modport slave (
        input  iBUS_REQ, iBUS_RW, iBUS_ADDR, iBUS_DATA, iBUS_BUSY, iSPECIAL_DATA,
        output oBUS_BUSY, oBUS_VALID, oBUS_ERR, oBUS_DATA,
        output oSPECIAL_REQ, oSPECIAL_RW, oSPECIAL_ADDR, oSPECIAL_DATA
    );

    modport master (
        output iBUS_REQ, iBUS_RW, iBUS_ADDR, iBUS_DATA, iBUS_BUSY, iSPECIAL_DATA,
        input  oBUS_BUSY, oBUS_VALID, oBUS_ERR, oBUS_DATA,
        input  oSPECIAL_REQ, oSPECIAL_RW, oSPECIAL_ADDR, oSPECIAL_DATA
    );

endinterface

// File: rtl/device_special_req_fifo.sv
// -----------------------------------------------------------------------------
// device_special_req_fifo
// Synchronous FIFO, 2**DEPTH_LOG2 entries of WIDTH bits, show-ahead read.
//   i_clk, i_rst_n  clock, synchronous active-low reset
//   i_push, i_data  write side (ignored when full)
//   i_pop           read side (ignored when empty)
//   o_data          current head entry
//   o_full, o_empty occupancy flags
// Pointers carry one extra bit so full and empty differ only in that bit.
// -----------------------------------------------------------------------------
module device_special_req_fifo #(
    parameter int DEPTH_LOG2 = 2,
    parameter int WIDTH      = 8
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_data,
    output logic             o_full,
    output logic             o_empty
);
    localparam int DEPTH = 1 << DEPTH_LOG2;

    logic [WIDTH-1:0]    r_mem [DEPTH];
    logic [DEPTH_LOG2:0] r_wr_ptr;
    logic [DEPTH_LOG2:0] r_rd_ptr;
    logic                w_do_push;
    logic                w_do_pop;

    assign o_empty   = (r_wr_ptr == r_rd_ptr);
    assign o_full    = (r_wr_ptr[DEPTH_LOG2] != r_rd_ptr[DEPTH_LOG2]) &&
                       (r_wr_ptr[DEPTH_LOG2-1:0] == r_rd_ptr[DEPTH_LOG2-1:0]);
    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop && !o_empty;
    assign o_data    = r_mem[r_rd_ptr[DEPTH_LOG2-1:0]];

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    // NOTE: the storage array is deliberately not reset; the pointers alone
    // define which entries are valid, so clearing data would only cost logic.
    always_ff @(posedge i_clk) begin
        if (w_do_push) r_mem[r_wr_ptr[DEPTH_LOG2-1:0]] <= i_data;
    end

endmodule

// File: rtl/device_special_access_ctrl.sv
// -----------------------------------------------------------------------------
// device_special_access_ctrl
// Accepts word accesses to the special address space, queues them in
// acceptance order and performs them one at a time on the special-memory
// port, returning exactly one response per accepted request.
//   iCLOCK   sole clock
//   inRESET  synchronous active-low reset
//   bus      device_special_access_if.slave (requester bus + memory port)
// Illegal addresses respond with ERR=1; writes to the first RO_ENTRIES words
// are dropped without touching memory but still respond with ERR=0.
// -----------------------------------------------------------------------------
module device_special_access_ctrl
    import device_special_access_pkg::*;
#(
    parameter int FIFO_DEPTH_N = 2,
    parameter int RO_ENTRIES   = 2
) (
    input  logic                          iCLOCK,
    input  logic                          inRESET,
    device_special_access_if.slave        bus
);
    localparam logic [INDEX_W-1:0] RO_LIMIT = INDEX_W'(RO_ENTRIES);

    state_t             r_state;
    state_t             w_next_state;
    req_entry_t         w_push_entry;
    req_entry_t         w_head_entry;
    req_entry_t         r_entry;
    logic [ENTRY_W-1:0] w_head_bits;
    logic               w_push;
    logic               w_pop;
    logic               w_full;
    logic               w_empty;
    logic               w_issue;
    logic [DATA_W-1:0]  r_resp_data;
    logic               r_resp_err;

    // ---------------- request decode and queue ----------------
    assign bus.oBUS_BUSY = w_full;
    assign w_push        = bus.iBUS_REQ && !w_full;

    always_comb begin
        w_push_entry       = '0;
        w_push_entry.rw    = bus.iBUS_RW;
        w_push_entry.err   = addr_is_err(bus.iBUS_ADDR);
        w_push_entry.index = bus.iBUS_ADDR[INDEX_MSB:INDEX_LSB];
        w_push_entry.ro    = bus.iBUS_RW && !addr_is_err(bus.iBUS_ADDR) &&
                             (bus.iBUS_ADDR[INDEX_MSB:INDEX_LSB] < RO_LIMIT);
        w_push_entry.data  = bus.iBUS_RW ? bus.iBUS_DATA : '0;
    end

    device_special_req_fifo #(
        .DEPTH_LOG2 (FIFO_DEPTH_N),
        .WIDTH      (ENTRY_W)
    ) u_fifo (
        .i_clk   (iCLOCK),
        .i_rst_n (inRESET),
        .i_push  (w_push),
        .i_data  (w_push_entry),
        .i_pop   (w_pop),
        .o_data  (w_head_bits),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    assign w_head_entry = req_entry_t'(w_head_bits);

    // ---------------- FSM ----------------
    always_ff @(posedge iCLOCK) begin
        if (!inRESET) r_state <= ST_IDLE;
        else          r_state <= w_next_state;
    end

    // NOTE: every signal driven here gets a default first, so no path through
    // the case leaves a value unassigned and no latch is inferred.
    always_comb begin
        w_next_state      = r_state;
        w_pop             = 1'b0;
        w_issue           = (r_state == ST_ISSUE);
        bus.oSPECIAL_REQ  = 1'b0;
        bus.oSPECIAL_RW   = 1'b0;
        bus.oSPECIAL_ADDR = '0;
        bus.oSPECIAL_DATA = '0;
        bus.oBUS_VALID    = 1'b0;
        bus.oBUS_ERR      = 1'b0;
        bus.oBUS_DATA     = '0;

        unique case (r_state)
            ST_IDLE: begin
                if (!w_empty) begin
                    w_pop        = 1'b1;
                    w_next_state = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                // Strobe is suppressed during reset so a pending write can
                // never land in memory on the reset edge.
                bus.oSPECIAL_REQ  = !r_entry.err && !r_entry.ro && inRESET;
                bus.oSPECIAL_RW   = r_entry.rw;
                bus.oSPECIAL_ADDR = r_entry.index;
                bus.oSPECIAL_DATA = r_entry.data;
                w_next_state      = ST_RESP;
            end
            ST_RESP: begin
                bus.oBUS_VALID = 1'b1;
                bus.oBUS_ERR   = r_resp_err;
                bus.oBUS_DATA  = r_resp_data;
                if (!bus.iBUS_BUSY) w_next_state = ST_IDLE;
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    // ---------------- in-flight entry and response capture ----------------
    always_ff @(posedge iCLOCK) begin
        if (!inRESET) begin
            r_entry     <= '0;
            r_resp_data <= '0;
            r_resp_err  <= 1'b0;
        end else begin
            if (w_pop) r_entry <= w_head_entry;
            // Captured only on the ISSUE edge, so RESP holds it unchanged.
            if (w_issue) begin
                r_resp_err  <= r_entry.err;
                r_resp_data <= (!r_entry.rw && !r_entry.err) ? bus.iSPECIAL_DATA : '0;
            end
        end
    end

endmodule

// File: doc/device_special_access_ctrl.md
DEVICE_SPECIAL_ACCESS_CTRL -- requirements
Module: device_special_access_ctrl

Interface
REQ-001 SHALL have parameter FIFO_DEPTH_N, default 2, meaning log2 of request-queue depth (4 entries).
REQ-002 SHALL have parameter RO_ENTRIES, default 2, meaning special-memory words 0..RO_ENTRIES-1 (USEMEMSIZE, PRIORITY) are read-only from the bus.
REQ-003 iCLOCK  in  1  sole clock, all state on rising edge.
REQ-004 inRESET  in  1  reset, synchronous, active-low.
REQ-005 iBUS_REQ  in  1  bus request valid.
REQ-006 oBUS_BUSY  out  1  request queue full; request not accepted.
REQ-007 iBUS_RW  in  1  1=write, 0=read.
REQ-008 iBUS_ADDR  in  32  byte address of special space.
REQ-009 iBUS_DATA  in  32  write data.
REQ-010 oBUS_VALID  out  1  response valid.
REQ-011 oBUS_ERR  out  1  response error flag, qualified by oBUS_VALID.
REQ-012 oBUS_DATA  out  32  read data, qualified by oBUS_VALID.
REQ-013 iBUS_BUSY  in  1  requester cannot take response.
REQ-014 oSPECIAL_REQ  out  1  special-memory access strobe.
REQ-015 oSPECIAL_RW  out  1  special-memory write enable.
REQ-016 oSPECIAL_ADDR  out  8  special-memory word index.
REQ-017 oSPECIAL_DATA  out  32  special-memory write data.
REQ-018 iSPECIAL_DATA  in  32  special-memory combinational read data.

Function
REQ-019 Request SHALL be accepted on an edge where iBUS_REQ=1 and oBUS_BUSY=0; it is decoded and pushed into the queue on that edge.
REQ-020 Decode: index=iBUS_ADDR[9:2]; error if iBUS_ADDR[1:0]!=0 or iBUS_ADDR[31:10]!=0; write to index<RO_ENTRIES flagged read-only-drop (not an error).
REQ-021 oBUS_BUSY SHALL equal queue-full; a pop in the same cycle does not permit a push.
REQ-022 FSM states IDLE, ISSUE, RESP; IDLE->ISSUE pops head when queue non-empty; ISSUE->RESP unconditionally; RESP->IDLE on edge with iBUS_BUSY=0, else hold.
REQ-023 In ISSUE, oSPECIAL_REQ=1 for exactly one cycle unless entry has error or read-only-drop; oSPECIAL_RW/ADDR/DATA from popped entry; outputs zero outside ISSUE.
REQ-024 In ISSUE, read data SHALL be captured from iSPECIAL_DATA; writes and errors return oBUS_DATA=0.
REQ-025 oBUS_VALID=1 only in RESP; oBUS_DATA/oBUS_ERR held stable while RESP holds.
REQ-026 Latency: with empty queue and IDLE, oBUS_VALID SHALL be high in the cycle after the 2nd edge following acceptance.
REQ-027 Responses SHALL be returned in acceptance order, one per request, including errors and dropped writes.
REQ-028 Queue pointers SHALL wrap modulo 2^FIFO_DEPTH_N; full and empty distinguished by an extra pointer bit.
REQ-029 Push during IDLE-pop of the same queue SHALL both take effect.
REQ-030 oSPECIAL_REQ SHALL be gated low while inRESET=0, preventing a memory write in the reset cycle.

Reset
REQ-031 On an edge with inRESET=0: state=IDLE, queue empty, pointers 0, response registers 0.
REQ-032 Reset values: oBUS_BUSY=0, oBUS_VALID=0, oBUS_ERR=0, oBUS_DATA=0, oSPECIAL_* all 0.
REQ-033 Reset mid-operation SHALL discard all queued and in-flight requests without response.

Structure
REQ-034 Package device_special_access_pkg SHALL hold FSM state encoding, entry field widths (rw 1, err 1, ro 1, index 8, data 32) and address-range constants.
REQ-035 Queue SHALL be sub-module device_special_req_fifo (parameterised depth/width, push/pop/full/empty).

Verification
REQ-036 Read addr 0x0000_0004, memory word1=0x0000_0003 -> oSPECIAL_REQ=1 RW=0 ADDR=0x01 for one cycle; response VALID, ERR=0, DATA=0x0000_0003 at REQ-026 latency.
REQ-037 Write addr 0x0000_0008 data 0xDEAD_BEEF, then read 0x0000_0008 -> one write strobe ADDR=0x02; read returns 0xDEAD_BEEF.
REQ-038 Write addr 0x0000_0000 data 0x1234_5678 -> no oSPECIAL_REQ, ERR=0; subsequent read of 0x0000_0000 returns reset USEMEMSIZE value.
REQ-039 Reads at 0x0000_0006 and 0x0000_0400 -> no oSPECIAL_REQ, ERR=1, DATA=0, both responses in order.
REQ-040 iBUS_BUSY=1 held, 5 back-to-back requests -> oBUS_BUSY=1 after queue full; releasing returns all accepted responses in order, none lost or duplicated.
REQ-041 inRESET=0 asserted while FSM in ISSUE with write queued -> no oSPECIAL_REQ in reset cycle; after release all outputs 0, no stale response.
